synchronizer: RTL and testbench

//   Input conditioning for the traffic-light controller. Brings the asynchronous

---
 rtl/sync_pkg.sv | 13 +
 rtl/synchronizer_if.sv | 22 ++
 rtl/sync_cell.sv | 32 +++
 rtl/synchronizer.sv | 87 ++++++++
 tb/tb_synchronizer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/sync_pkg.sv
// Shared constants for the input synchronizer slice: default chain depth,
// default debounce length and the debounce counter width.
package sync_pkg;

    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned DEBOUNCE_CNT_W          = $clog2(DEBOUNCE_CYCLES_DEFAULT + 1);

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/synchronizer_if.sv
// Raw asynchronous inputs and their clk-domain counterparts.
// The master drives the raw side; the slave (the synchronizer) drives *_sync.
interface synchronizer_if;

    logic sensor;
    logic walk_request;
    logic reprogram;
    logic sensor_sync;
    logic wr_sync;
    logic prog_sync;

    modport master (
        output sensor, walk_request, reprogram,
        input  sensor_sync, wr_sync, prog_sync
    );

    modport slave (
        input  sensor, walk_request, reprogram,
        output sensor_sync, wr_sync, prog_sync
    );

endinterface

// File: rtl/sync_cell.sv
// One multi-flop synchronizer chain with asynchronous clear to RESET_VAL.
// The output is the last flop; latency is exactly STAGES rising edges.
module sync_cell
    import sync_pkg::*;
#(
    parameter int unsigned STAGES    = SYNC_STAGES_DEFAULT,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/synchronizer.sv
// Input conditioning for the traffic-light controller: reset, sensor,
// walk_request and reprogram brought into clk. Optional debounce: SYNC_DEBOUNCE_EN.
module synchronizer
    import sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    output logic           reset_sync,
    synchronizer_if.slave  sif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("synchronizer: SYNC_STAGES must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    logic sensor_s;
    logic wr_s;
    logic prog_s;

    // Reset chain: set asynchronously, shifts in 0 after release.
    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_reset_cell (
        .clk (clk), .clr (reset), .d (1'b0), .q (reset_sync)
    );

    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sensor_cell (
        .clk (clk), .clr (reset), .d (sif.sensor), .q (sensor_s)
    );

    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_wr_cell (
        .clk (clk), .clr (reset), .d (sif.walk_request), .q (wr_s)
    );

    sync_cell #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_prog_cell (
        .clk (clk), .clr (reset), .d (sif.reprogram), .q (prog_s)
    );

    assign sif.prog_sync = prog_s;

`ifdef SYNC_DEBOUNCE_EN
    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    // Index 0 = sensor, 1 = walk_request.
    logic [1:0]            raw_s;
    logic [1:0]            deb_q;
    logic [1:0]            deb_d;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    assign raw_s = {wr_s, sensor_s};

    // Count consecutive cycles the synced value differs from the output;
    // any return to the output value restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (raw_s[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = raw_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign sif.sensor_sync = deb_q[0];
    assign sif.wr_sync     = deb_q[1];
`else
    assign sif.sensor_sync = sensor_s;
    assign sif.wr_sync     = wr_s;
`endif

endmodule

// File: tb/tb_synchronizer.sv
// Directed self-checking bench for synchronizer (SYNC_STAGES=2, debounce off).
// Rising clock edges at t=5,15,25,...; checks sampled 1 time unit after edges.
module tb_synchronizer;

    logic clk;
    logic clk_run;
    logic reset;
    logic reset_sync;

    int unsigned tests_run;
    int unsigned tests_failed;

    synchronizer_if sif ();

    synchronizer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_sync (reset_sync),
        .sif        (sif)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic at_time(input int unsigned t);
        if ($time < t) #(t - $time);
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        clk_run          = 1'b0;
        reset            = 1'b0;
        sif.sensor       = 1'b0;
        sif.walk_request = 1'b0;
        sif.reprogram    = 1'b0;

        // Reset with the clock stopped
        at_time(1);
        reset = 1'b1;
        #1;
        check("rst_reset_sync", reset_sync, 1'b1);
        check("rst_sensor_sync", sif.sensor_sync, 1'b0);
        check("rst_wr_sync", sif.wr_sync, 1'b0);
        check("rst_prog_sync", sif.prog_sync, 1'b0);
        clk_run = 1'b1;

        // Release at 22: still asserted after edge 25, clear after edge 35
        at_time(22);
        reset = 1'b0;
        at_time(26);
        check("rel_reset_sync_e1", reset_sync, 1'b1);
        at_time(36);
        check("rel_reset_sync_e2", reset_sync, 1'b0);

        // sensor and reprogram rise at 40: sampled at 45, visible after 55
        at_time(40);
        sif.sensor    = 1'b1;
        sif.reprogram = 1'b1;
        at_time(50);
        check("rise_sensor_early", sif.sensor_sync, 1'b0);
        check("rise_prog_early", sif.prog_sync, 1'b0);
        at_time(56);
        check("rise_sensor", sif.sensor_sync, 1'b1);
        check("rise_prog", sif.prog_sync, 1'b1);
        check("rise_wr_idle", sif.wr_sync, 1'b0);

        // One-period walk pulse 60..70 and reprogram fall at 60
        at_time(60);
        sif.walk_request = 1'b1;
        sif.reprogram    = 1'b0;
        at_time(66);
        check("pulse_wr_e1", sif.wr_sync, 1'b0);
        check("fall_prog_e1", sif.prog_sync, 1'b1);
        at_time(70);
        sif.walk_request = 1'b0;
        at_time(76);
        check("pulse_wr_e2", sif.wr_sync, 1'b1);
        check("fall_prog_e2", sif.prog_sync, 1'b0);
        at_time(86);
        check("pulse_wr_e3", sif.wr_sync, 1'b0);
        check("hold_sensor", sif.sensor_sync, 1'b1);

        // Reset mid-operation between edges
        at_time(92);
        reset = 1'b1;
        #1;
        check("midrst_sensor_sync", sif.sensor_sync, 1'b0);
        check("midrst_reset_sync", reset_sync, 1'b1);
        at_time(102);
        reset = 1'b0;
        at_time(106);
        check("rel2_sensor_e1", sif.sensor_sync, 1'b0);
        check("rel2_reset_e1", reset_sync, 1'b1);
        at_time(116);
        check("rel2_sensor_e2", sif.sensor_sync, 1'b1);
        check("rel2_reset_e2", reset_sync, 1'b0);

        // Simultaneous changes on all three chains at 120
        at_time(120);
        sif.sensor       = 1'b0;
        sif.walk_request = 1'b1;
        sif.reprogram    = 1'b1;
        at_time(126);
        check("simul_sensor_e1", sif.sensor_sync, 1'b1);
        check("simul_wr_e1", sif.wr_sync, 1'b0);
        check("simul_prog_e1", sif.prog_sync, 1'b0);
        at_time(136);
        check("simul_sensor_e2", sif.sensor_sync, 1'b0);
        check("simul_wr_e2", sif.wr_sync, 1'b1);
        check("simul_prog_e2", sif.prog_sync, 1'b1);

        // Sub-period glitch 140..143 falls between edges and is lost
        at_time(140);
        sif.sensor = 1'b1;
        at_time(143);
        sif.sensor = 1'b0;
        at_time(156);
        check("glitch_sensor_e2", sif.sensor_sync, 1'b0);
        at_time(166);
        check("glitch_sensor_e3", sif.sensor_sync, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
